// File: rtl/kbd_ctrl.sv
// PS/2 keyboard host controller: reset/BAT handshake, scan-byte forwarding, lock LEDs.
// Lock-LED tracking and the LED command sequence exist only when KBD_CTRL_LEDS_EN is defined.
module kbd_ctrl #(
  parameter logic [23:0] TIMEOUT   = 24'd2_000_000,
  parameter int          MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] scan,
  output logic       scanrdy,
  output logic [2:0] leds,
  output logic       init_done,
  output logic       err
);
  localparam int            RW          = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    INIT_TX  = 3'd0,
    INIT_ACK = 3'd1,
    INIT_BAT = 3'd2,
    IDLE     = 3'd3
`ifdef KBD_CTRL_LEDS_EN
    ,
    LED_TX0  = 3'd4,
    LED_ACK0 = 3'd5,
    LED_TX1  = 3'd6,
    LED_ACK1 = 3'd7
`endif
  } state_t;

  state_t        state;
  state_t        retry_state;
  logic [23:0]   count;
  logic [RW-1:0] retries;
  logic          wait_done;
  logic          ack_state;
  logic          got_ok;
  logic          got_retry;
  logic          consume;
  logic          waiting;
  logic          do_retry;
`ifdef KBD_CTRL_LEDS_EN
  logic          ext;
  logic          brk;
  logic          led_pend;
`endif

  // Classify the incoming byte against what the current state expects.
  always_comb begin
    ack_state = (state == INIT_ACK);
`ifdef KBD_CTRL_LEDS_EN
    ack_state = ack_state || (state == LED_ACK0) || (state == LED_ACK1);
`endif
    if (rx_rdy && ack_state) begin
      got_ok    = (rx_data == 8'hFA);
      got_retry = (rx_data == 8'hFE);
    end else if (rx_rdy && (state == INIT_BAT)) begin
      got_ok    = (rx_data == 8'hAA);
      got_retry = (rx_data == 8'hFE) || (rx_data == 8'hFC);
    end else begin
      got_ok    = 1'b0;
      got_retry = 1'b0;
    end
    consume  = got_ok || got_retry;
    // Timeout only runs once the transmitter has finished the byte.
    waiting  = (ack_state || (state == INIT_BAT)) && !wait_done;
    do_retry = got_retry || (waiting && !rx_rdy && (count >= TIMEOUT - 24'd1));
    case (state)
`ifdef KBD_CTRL_LEDS_EN
      LED_ACK0: retry_state = LED_TX0;
      LED_ACK1: retry_state = LED_TX1;
`endif
      default:  retry_state = INIT_TX;
    endcase
  end

  // Command FSM, timeout counter, retry bookkeeping and scan forwarding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT_TX;
      count     <= 24'd0;
      retries   <= '0;
      wait_done <= 1'b0;
      tx_req    <= 1'b0;
      tx_data   <= 8'h00;
      scan      <= 8'h00;
      scanrdy   <= 1'b0;
      leds      <= 3'b000;
      init_done <= 1'b0;
      err       <= 1'b0;
`ifdef KBD_CTRL_LEDS_EN
      ext       <= 1'b0;
      brk       <= 1'b0;
      led_pend  <= 1'b0;
`endif
    end else begin
      tx_req  <= 1'b0;
      scanrdy <= 1'b0;
      if (tx_done) wait_done <= 1'b0;
      if (rx_rdy || !waiting) count <= 24'd0;
      else                    count <= count + 24'd1;

      if (do_retry) begin
        count     <= 24'd0;
        wait_done <= 1'b0;
        if (retries >= RETRY_LIMIT) begin
          err     <= 1'b1;
          retries <= '0;
          state   <= IDLE;
        end else begin
          retries <= retries + RW'(1);
          state   <= retry_state;
        end
      end else begin
        case (state)
          INIT_TX: if (!tx_busy) begin
            tx_req    <= 1'b1;
            tx_data   <= 8'hFF;
            wait_done <= 1'b1;
            state     <= INIT_ACK;
          end
          INIT_ACK: if (got_ok) state <= INIT_BAT;
          INIT_BAT: if (got_ok) begin
            init_done <= 1'b1;
            retries   <= '0;
            state     <= IDLE;
          end
`ifdef KBD_CTRL_LEDS_EN
          IDLE: if (led_pend) begin
            led_pend <= 1'b0;
            retries  <= '0;
            state    <= LED_TX0;
          end
          LED_TX0: if (!tx_busy) begin
            tx_req    <= 1'b1;
            tx_data   <= 8'hED;
            wait_done <= 1'b1;
            state     <= LED_ACK0;
          end
          LED_ACK0: if (got_ok) begin
            retries <= '0;
            state   <= LED_TX1;
          end
          LED_TX1: if (!tx_busy) begin
            tx_req    <= 1'b1;
            tx_data   <= {5'b00000, leds};
            wait_done <= 1'b1;
            state     <= LED_ACK1;
          end
          LED_ACK1: if (got_ok) state <= IDLE;
`else
          IDLE: state <= IDLE;
`endif
          default: state <= INIT_TX;
        endcase
      end

      if (rx_rdy && !consume) begin
        scanrdy <= 1'b1;
        scan    <= rx_data;
`ifdef KBD_CTRL_LEDS_EN
        if (rx_data == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_data == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // Placed after the FSM so a toggle in the IDLE hand-off cycle re-arms led_pend.
          if (!ext && !brk) begin
            case (rx_data)
              8'h58: begin leds[2] <= ~leds[2]; led_pend <= 1'b1; end
              8'h77: begin leds[1] <= ~leds[1]; led_pend <= 1'b1; end
              8'h7E: begin leds[0] <= ~leds[0]; led_pend <= 1'b1; end
              default: ;
            endcase
          end
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed bench for kbd_ctrl with tx/scan scoreboards and a small keyboard/transmitter model.
module tb_kbd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] scan;
  logic       scanrdy;
  logic [2:0] leds;
  logic       init_done;
  logic       err;

  typedef struct {
    logic [7:0] b;
    int         due;
  } fwd_t;

  fwd_t       scan_q[$];
  logic [7:0] tx_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tx_count = 0;
  int scan_count = 0;
  logic prev_tx_req = 1'b0;

  kbd_ctrl #(.TIMEOUT(24'd40), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done),
    .scan(scan), .scanrdy(scanrdy), .leds(leds), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every tx_req and scanrdy strobe is matched against the queues.
  always @(negedge clk) begin
    prev_tx_req <= tx_req;
    if (tx_req) begin
      tx_count <= tx_count + 1;
      check("tx_req_width", {31'd0, prev_tx_req}, 32'd0);
      check("tx_expected", {31'd0, tx_q.size() > 0}, 32'd1);
      if (tx_q.size() > 0) begin
        check("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0]});
        void'(tx_q.pop_front());
      end
    end
    if (scanrdy) begin
      scan_count <= scan_count + 1;
      check("scan_expected", {31'd0, scan_q.size() > 0}, 32'd1);
      if (scan_q.size() > 0) begin
        check("scan_data", {24'd0, scan}, {24'd0, scan_q[0].b});
        check("scan_latency", cyc, scan_q[0].due);
        void'(scan_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit fwd);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    if (fwd) scan_q.push_back('{b, cyc + 1});
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic serve_tx(input logic [7:0] b, input int done_delay, input string tag);
    int start;
    int waited;
    start  = tx_count;
    waited = 0;
    tx_q.push_back(b);
    while (tx_count == start && waited < 120) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_sent"}, tx_count - start, 32'd1);
    tx_busy = 1'b1;
    tick(done_delay);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_req"},    {31'd0, tx_req},    32'd0);
    check({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
    check({tag, "_scanrdy"},   {31'd0, scanrdy},   32'd0);
    check({tag, "_scan"},      {24'd0, scan},      32'd0);
    check({tag, "_leds"},      {29'd0, leds},      32'd0);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst     = 1'b0;
    rx_rdy  = 1'b0;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    tick(1);
    check_reset_outputs(tag);
    tick(1);
    rst = 1'b1;
  endtask

  task automatic wait_err(input int limit);
    int w;
    w = 0;
    while (!err && w < limit) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Directed sequence.
  initial begin
    int base;
    rst = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    tick(3);
    check_reset_outputs("reset");

    // Init handshake, first with the transmitter busy.
    tx_busy = 1'b1;
    rst = 1'b1;
    tick(5);
    check("busy_hold", tx_count, 32'd0);
    tx_busy = 1'b0;
    serve_tx(8'hFF, 3, "init_ff");
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    tick(2);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_err", {31'd0, err}, 32'd0);
    check("init_tx_count", tx_count, 32'd1);
    check("init_no_scan", scan_count, 32'd0);

    // Forwarding in IDLE; response bytes are ordinary data here.
    send_rx(8'h1C, 1'b1);
    send_rx(8'hF0, 1'b1);
    send_rx(8'h1C, 1'b1);
    send_rx(8'hFA, 1'b1);
    tick(3);
    check("fwd_count", scan_count, 32'd4);
    check("scan_hold", {24'd0, scan}, 32'h0000_00FA);

`ifdef KBD_CTRL_LEDS_EN
    send_rx(8'h58, 1'b1);
    check("caps_leds", {29'd0, leds}, 32'd4);
    serve_tx(8'hED, 2, "led_cmd");
    send_rx(8'hFA, 1'b0);
    serve_tx(8'h04, 2, "led_mask");
    send_rx(8'hFA, 1'b0);
    send_rx(8'h77, 1'b1);
    check("num_leds", {29'd0, leds}, 32'd6);
    serve_tx(8'hED, 2, "ed_try1");
    send_rx(8'hFE, 1'b0);
    serve_tx(8'hED, 2, "ed_try2");
    send_rx(8'hFE, 1'b0);
    serve_tx(8'hED, 2, "ed_try3");
    send_rx(8'hFA, 1'b0);
    serve_tx(8'h06, 2, "mask_06");
    send_rx(8'hFA, 1'b0);
    tick(2);
    check("led_retry_err", {31'd0, err}, 32'd0);
    base = tx_count;
    send_rx(8'hF0, 1'b1);
    send_rx(8'h58, 1'b1);
    tick(20);
    check("break_no_toggle", {29'd0, leds}, 32'd6);
    check("break_no_tx", tx_count - base, 32'd0);
    send_rx(8'h58, 1'b1);
    serve_tx(8'hED, 2, "pre_abort");
    tick(2);
    reset_dut("led_abort");
    serve_tx(8'hFF, 2, "reinit");
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    tick(2);
    check("reinit_done", {31'd0, init_done}, 32'd1);
`else
    base = tx_count;
    send_rx(8'h58, 1'b1);
    tick(20);
    check("lock_leds_off", {29'd0, leds}, 32'd0);
    check("lock_no_tx", tx_count - base, 32'd0);
`endif

    // Reset mid-command, then retries right up to the limit.
    reset_dut("idle_reset");
    serve_tx(8'hFF, 2, "mid");
    tick(3);
    reset_dut("mid_abort");
    serve_tx(8'hFF, 2, "r1");
    send_rx(8'hFE, 1'b0);
    serve_tx(8'hFF, 2, "r2");
    send_rx(8'hFA, 1'b0);
    send_rx(8'hFC, 1'b0);
    serve_tx(8'hFF, 2, "r3");
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    tick(2);
    check("retry_init_done", {31'd0, init_done}, 32'd1);
    check("retry_err", {31'd0, err}, 32'd0);

    // Silent keyboard: timeout only counts after tx_done, then error after the last resend.
    reset_dut("to_reset");
    base = tx_count;
    serve_tx(8'hFF, 80, "to1");
    check("no_timeout_while_busy", tx_count - base, 32'd1);
    serve_tx(8'hFF, 2, "to2");
    serve_tx(8'hFF, 2, "to3");
    wait_err(300);
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_init_done", {31'd0, init_done}, 32'd0);
    check("timeout_tx_total", tx_count - base, 32'd3);
    tick(100);
    check("idle_after_err", tx_count - base, 32'd3);
    send_rx(8'h1C, 1'b1);
    send_rx(8'hFA, 1'b1);
    tick(3);
    check("err_sticky", {31'd0, err}, 32'd1);

    check("scan_q_drained", scan_q.size(), 32'd0);
    check("tx_q_drained", tx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
